// File: rtl/tt_um_ronmsjsu_prbs31.sv
// PRBS31 (x^31 + x^28 + 1) generator tile, serial or byte-wide output.
// Define PRBS31_CHECKER_EN to build the self-synchronising checker; otherwise its outputs and readback are 0.
module tt_um_ronmsjsu_prbs31 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [30:0] lfsr, lfsr_next, lfsr_8;
    logic [7:0]  gen, gen_next, raw_bits, emit_bits, uo_next, rb_next;
    logic        last_bit, last_next;
    logic        inj_prev, inj_flag, inj_flag_next, inj_arm;
    logic        run, byte_mode, invert;
    logic        lock, err_pulse, sticky;
    logic        unused_inputs;

    assign run       = ui_in[0];
    assign byte_mode = ui_in[1];
    assign invert    = ui_in[2];

    function automatic logic [30:0] lfsr_step(input logic [30:0] s);
        return {s[29:0], s[30] ^ s[27]};
    endfunction

    // Eight look-ahead steps; the first step's bit ends up in bit7.
    always_comb begin
        lfsr_8   = lfsr;
        raw_bits = '0;
        for (int i = 0; i < 8; i++) begin
            raw_bits = {raw_bits[6:0], lfsr_8[30] ^ lfsr_8[27]};
            lfsr_8   = lfsr_step(lfsr_8);
        end
    end

    // An edge arriving on an advancing clock is consumed immediately.
    assign inj_arm   = inj_flag | (ui_in[3] & ~inj_prev);
    assign emit_bits = raw_bits ^ {8{invert}} ^ {inj_arm, 7'b0};

    always_comb begin
        lfsr_next     = lfsr;
        gen_next      = gen;
        last_next     = last_bit;
        inj_flag_next = inj_arm;
        if (run) begin
            inj_flag_next = 1'b0;
            if (byte_mode) begin
                lfsr_next = lfsr_8;
                gen_next  = emit_bits;
                last_next = emit_bits[0];
            end else begin
                lfsr_next = lfsr_step(lfsr);
                gen_next  = {gen[6:0], emit_bits[7]};
                last_next = emit_bits[7];
            end
        end
    end

`ifdef PRBS31_CHECKER_EN
    logic [30:0] hist, hist_next;
    logic [4:0]  fill, fill_next, quiet, quiet_next;
    logic [7:0]  cnt, cnt_next;
    logic        lock_next, err_next, sticky_next, rx_bit, mismatch;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign rx_bit   = uio_in[0] ^ invert;
    assign mismatch = rx_bit != (hist[30] ^ hist[27]);

    // quiet counts the clean compares still needed after a mismatch before lock may assert.
    always_comb begin
        hist_next   = hist;
        fill_next   = fill;
        quiet_next  = quiet;
        cnt_next    = cnt;
        lock_next   = lock;
        err_next    = 1'b0;
        sticky_next = sticky;
        if (ui_in[6]) begin
            hist_next   = '0;
            fill_next   = '0;
            quiet_next  = '0;
            cnt_next    = '0;
            lock_next   = 1'b0;
            sticky_next = 1'b0;
        end else if (ui_in[4]) begin
            hist_next = {hist[29:0], rx_bit};
            if (fill != 5'd31) begin
                fill_next = fill + 5'd1;
            end else if (mismatch) begin
                err_next    = 1'b1;
                sticky_next = 1'b1;
                cnt_next    = sat_inc8(cnt);
                quiet_next  = 5'd31;
            end else if (quiet != 5'd0) begin
                quiet_next = quiet - 5'd1;
            end
            lock_next = (fill_next == 5'd31) && (quiet_next == 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist      <= '0;
            fill      <= '0;
            quiet     <= '0;
            cnt       <= '0;
            lock      <= 1'b0;
            err_pulse <= 1'b0;
            sticky    <= 1'b0;
        end else begin
            hist      <= hist_next;
            fill      <= fill_next;
            quiet     <= quiet_next;
            cnt       <= cnt_next;
            lock      <= lock_next;
            err_pulse <= err_next;
            sticky    <= sticky_next;
        end
    end

    assign rb_next       = cnt_next;
    assign unused_inputs = ^{ena, ui_in[7], uio_in[7:1]};
`else
    assign lock          = 1'b0;
    assign err_pulse     = 1'b0;
    assign sticky        = 1'b0;
    assign rb_next       = 8'd0;
    assign unused_inputs = ^{ena, ui_in[7], ui_in[6], ui_in[4], uio_in};
`endif

    assign uo_next = ui_in[5] ? rb_next : gen_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr     <= '1;
            gen      <= '0;
            last_bit <= 1'b0;
            inj_prev <= 1'b0;
            inj_flag <= 1'b0;
            uo_out   <= '0;
        end else begin
            lfsr     <= lfsr_next;
            gen      <= gen_next;
            last_bit <= last_next;
            inj_prev <= ui_in[3];
            inj_flag <= inj_flag_next;
            uo_out   <= uo_next;
        end
    end

    assign uio_out = {sticky, last_bit, lock, err_pulse, 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_ronmsjsu_prbs31.sv
// Bench for tt_um_ronmsjsu_prbs31: sequence-level model checked every clock plus directed literal checks.
module tb_tt_um_ronmsjsu_prbs31;

`ifdef PRBS31_CHECKER_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk, rst_n, ena;
    logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
    logic       loop, const_bit;
    int         tests = 0;
    int         fails = 0;

    assign uio_in = {7'b0, loop ? uio_out[6] : const_bit};

    tt_um_ronmsjsu_prbs31 dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference PRBS31 sequence: b[n] = b[n-31] ^ b[n-28], with all bits before n=0 equal to 1.
    bit pr [0:8191];
    initial begin
        for (int n = 0; n < 8192; n++)
            pr[n] = (n >= 31 ? pr[n-31] : 1'b1) ^ (n >= 28 ? pr[n-28] : 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    logic [7:0] c_ui, c_uin;
    logic       c_rst;
    int         m_idx, m_since;
    logic [7:0] m_gen, m_cnt, exp_uo, exp_uio;
    logic       m_last, m_prev3, m_flag, m_lock, m_err, m_sticky;
    bit         rxq [$];

    task automatic model_step();
        int         nb, n;
        logic [7:0] bv;
        logic       b, edge_i, arm, r;
        if (!c_rst) begin
            m_idx = 0; m_gen = 0; m_last = 0; m_prev3 = 0; m_flag = 0;
            rxq.delete(); m_cnt = 0; m_sticky = 0; m_lock = 0; m_err = 0; m_since = 31;
        end else begin
            edge_i  = c_ui[3] & ~m_prev3;
            m_prev3 = c_ui[3];
            arm     = m_flag | edge_i;
            if (c_ui[0]) begin
                nb = c_ui[1] ? 8 : 1;
                bv = 0;
                for (int k = 0; k < nb; k++) begin
                    b  = pr[m_idx+k] ^ c_ui[2] ^ ((k == 0) && arm);
                    bv = {bv[6:0], b};
                    if (!c_ui[1]) m_gen = {m_gen[6:0], b};
                    m_last = b;
                end
                if (c_ui[1]) m_gen = bv;
                m_idx  += nb;
                m_flag = 0;
            end else begin
                m_flag = arm;
            end
`ifdef PRBS31_CHECKER_EN
            m_err = 0;
            if (c_ui[6]) begin
                rxq.delete(); m_cnt = 0; m_sticky = 0; m_lock = 0; m_since = 31;
            end else if (c_ui[4]) begin
                r = c_uin[0] ^ c_ui[2];
                n = rxq.size();
                if (n >= 31) begin
                    if (r != (rxq[n-31] ^ rxq[n-28])) begin
                        m_err = 1; m_sticky = 1; m_since = 0;
                        if (m_cnt < 255) m_cnt = m_cnt + 1;
                    end else begin
                        m_since++;
                    end
                end
                rxq.push_back(r);
                m_lock = (rxq.size() >= 31) && (m_since >= 31);
            end
`endif
        end
        exp_uo  = (c_rst && c_ui[5]) ? m_cnt : m_gen;
        exp_uio = {m_sticky, m_last, m_lock, m_err, 4'b0000};
    endtask

    always @(posedge clk) begin
        c_ui  = ui_in;
        c_uin = uio_in;
        c_rst = rst_n;
        #1;
        model_step();
        check("model_uo_out", uo_out, exp_uo);
        check("model_uio_out", uio_out, exp_uio);
        check("model_uio_oe", uio_oe, 8'hF0);
    end

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ui_in = 8'h00;
        clocks(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; loop = 1'b0; const_bit = 1'b0;
        clocks(2);
        check("reset_uo_out", uo_out, 8'h00);
        check("reset_uio_out", uio_out, 8'h00);
        check("reset_uio_oe", uio_oe, 8'hF0);

        // Serial from sequence start
        rst_n = 1'b1; ui_in = 8'h01;
        clocks(28);
        check("serial_clk28", uo_out, 8'h00);
        clocks(1);
        check("serial_clk29", uo_out, 8'h01);
        check("serial_last29", uio_out[6], 1'b1);
        clocks(3);
        check("serial_clk32", uo_out, 8'h0E);

        // Byte mode
        do_reset(); ui_in = 8'h03;
        clocks(1); check("byte1", uo_out, 8'h00);
        clocks(1); check("byte2", uo_out, 8'h00);
        clocks(1); check("byte3", uo_out, 8'h00);
        clocks(1); check("byte4", uo_out, 8'h0E);
        check("byte4_last", uio_out[6], 1'b0);

        // Byte mode, inverted
        do_reset(); ui_in = 8'h07;
        clocks(1); check("inv_byte1", uo_out, 8'hFF);
        check("inv_byte1_last", uio_out[6], 1'b1);
        clocks(3); check("inv_byte4", uo_out, 8'hF1);

        // Inject armed while idle, applied on first advance
        do_reset(); ui_in = 8'h08;
        clocks(1); ui_in = 8'h00;
        clocks(2); check("inj_idle_hold", uo_out, 8'h00);
        ui_in = 8'h03;
        clocks(1); check("inj_byte1", uo_out, 8'h80);
        clocks(1); check("inj_byte2", uo_out, 8'h00);
        ui_in = 8'h01; clocks(5);
        ui_in = 8'h00; clocks(3);
        ui_in = 8'h03; clocks(2);
        ui_in = 8'h0B; clocks(1);
        ui_in = 8'h01; clocks(4);

        // Serial loopback into checker
        do_reset(); loop = 1'b1; ui_in = 8'h01;
        clocks(1); ui_in = 8'h11;
        clocks(40);
        check("loop_lock", uio_out[5], CHK);
        check("loop_sticky", uio_out[7], 1'b0);
        ui_in = 8'h31;
        clocks(1); check("loop_count0", uo_out, 8'h00);
        ui_in = 8'h39;
        clocks(1); ui_in = 8'h31;
        clocks(90);
        check("loop_inj_count_nonzero", uo_out != 8'h00, CHK);
        check("loop_inj_sticky", uio_out[7], CHK);
        check("loop_relock", uio_out[5], CHK);

        // Constant input: every compare fails
        do_reset(); loop = 1'b0; const_bit = 1'b1; ui_in = 8'h30;
        clocks(31); check("const_no_pulse_fill", uio_out[4], 1'b0);
        clocks(1);  check("const_first_pulse", uio_out[4], CHK);
        clocks(268);
        check("const_count_sat", uo_out, CHK ? 8'hFF : 8'h00);
        check("const_sticky", uio_out[7], CHK);
        check("const_lock_low", uio_out[5], 1'b0);
        ui_in = 8'h70;
        clocks(1);
        check("clear_count", uo_out, 8'h00);
        check("clear_status", uio_out, 8'h00);
        ui_in = 8'h30;
        clocks(5);
        check("post_clear_count", uo_out, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
